// File: rtl/vga_bar_pkg.sv
// vga_bar_pkg
//   Shared definitions for the VGA bar generator: the pattern-mode
//   encodings, a ceiling-log2 helper for sizing counters, and helpers
//   that derive the total line length and frame height from the timing
//   parameters.
//   No ports (package).
package vga_bar_pkg;

  // These are the pattern modes the bus register block can select.
  typedef enum logic [1:0] {
    MODE_VBARS  = 2'd0,
    MODE_SOLID  = 2'd1,
    MODE_BORDER = 2'd2,
    MODE_HBANDS = 2'd3
  } mode_e;

  // The minimum is one bit, so a count range of 1 still gets a real
  // register, for example the pixel divider when CLK_DIV=1.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // This gives the pixels per line: active, front porch, sync and back porch.
  function automatic int h_total(input int active, input int fp,
                                 input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // This gives the lines per frame, in the same order as the pixels per line.
  function automatic int v_total(input int active, input int fp,
                                 input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_bar_gen_timing.sv
// vga_timing_core
//   Holds the pixel-rate divider, the horizontal and vertical position
//   counters, and the raw (unregistered) sync/DE decode of the counters.
//   Ports:
//     i_clk     system clock
//     i_rst     synchronous active-high reset
//     i_enable  counting runs when 1; when 0 the counters are held at zero
//     o_h_cnt   horizontal position, 0..H_TOTAL-1
//     o_v_cnt   vertical position, 0..V_TOTAL-1
//     o_pix_ce  one-CLK pixel enable, high on the last divider count
//     o_hs_act  counters are inside the hsync window
//     o_vs_act  counters are inside the vsync window
//     o_de      counters are inside the active picture
module vga_timing_core
  import vga_bar_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HC_W    = clog2(H_TOTAL),
  localparam int VC_W    = clog2(V_TOTAL)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_enable,
  output logic [HC_W-1:0] o_h_cnt,
  output logic [VC_W-1:0] o_v_cnt,
  output logic            o_pix_ce,
  output logic            o_hs_act,
  output logic            o_vs_act,
  output logic            o_de
);

  localparam int DIV_W = clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HC_W-1:0]  H_LAST    = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0]  V_LAST    = VC_W'(V_TOTAL - 1);
  localparam logic [HC_W-1:0]  H_ACT     = HC_W'(H_ACTIVE);
  localparam logic [VC_W-1:0]  V_ACT     = VC_W'(V_ACTIVE);
  localparam logic [HC_W-1:0]  HS_FIRST  = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0]  HS_LAST   = HC_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VC_W-1:0]  VS_FIRST  = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0]  VS_LAST   = VC_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [HC_W-1:0]  r_h_cnt;
  logic [VC_W-1:0]  r_v_cnt;
  logic             w_pix_ce;

  // With CLK_DIV=1 the divider sits at zero, so this enable is always high.
  assign w_pix_ce = (r_div_cnt == DIV_LAST);

  // The divider and the raster counters advance here. Pulling enable low
  // has the same effect as reset, so a restart always begins at pixel (0,0).
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_div_cnt <= '0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else begin
      if (w_pix_ce) r_div_cnt <= '0;
      else          r_div_cnt <= r_div_cnt + 1'b1;

      if (w_pix_ce) begin
        if (r_h_cnt == H_LAST) begin
          r_h_cnt <= '0;
          if (r_v_cnt == V_LAST) r_v_cnt <= '0;
          else                   r_v_cnt <= r_v_cnt + 1'b1;
        end else begin
          r_h_cnt <= r_h_cnt + 1'b1;
        end
      end
    end
  end

  assign o_h_cnt  = r_h_cnt;
  assign o_v_cnt  = r_v_cnt;
  assign o_pix_ce = w_pix_ce;
  assign o_hs_act = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
  assign o_vs_act = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
  assign o_de     = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);

endmodule

// File: rtl/vga_bar_gen.sv
// vga_bar_gen
//   VGA timing generator with a test-pattern engine. The pixel rate comes
//   from a clock enable on i_clk. Colours and mode are captured once per
//   frame, and every output is registered one pixel behind the counters.
//   Ports:
//     i_clk          system clock
//     i_rst          synchronous active-high reset (has priority over enable)
//     i_enable       run when 1; when 0 the outputs are held in their reset state
//     i_mode         0 vertical bars, 1 solid, 2 border, 3 horizontal bands
//     i_bar_colors   bar k = [k*PIX_W +: PIX_W], packed {R,G,B}
//     i_solid_color  colour for solid mode and for the border
//     o_vga_hs/vs    sync outputs, active level HS_POL/VS_POL
//     o_vga_de       active-video flag
//     o_vga_r/g/b    colour outputs, zero during blanking
//     o_frame_start  one-CLK pulse when pixel (0,0) appears on the outputs
//     o_line_start   one-CLK pulse when x=0 of an active line appears
module vga_bar_gen
  import vga_bar_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 4,
  parameter int NUM_BARS = 8,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5,
  localparam int PIX_W   = R_W + G_W + B_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  input  logic [1:0]                i_mode,
  input  logic [NUM_BARS*PIX_W-1:0] i_bar_colors,
  input  logic [PIX_W-1:0]          i_solid_color,
  output logic                      o_vga_hs,
  output logic                      o_vga_vs,
  output logic                      o_vga_de,
  output logic [R_W-1:0]            o_vga_r,
  output logic [G_W-1:0]            o_vga_g,
  output logic [B_W-1:0]            o_vga_b,
  output logic                      o_frame_start,
  output logic                      o_line_start
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HC_W    = clog2(H_TOTAL);
  localparam int VC_W    = clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / NUM_BARS;
  // If there are more bars than lines, the band height is clamped to one
  // line. The band index then stays at zero instead of dividing to nothing.
  localparam int BAR_H   = (V_ACTIVE / NUM_BARS > 0) ? V_ACTIVE / NUM_BARS : 1;
  localparam int IDX_W   = clog2(NUM_BARS);
  localparam int BPX_W   = clog2(BAR_W);
  localparam int BPY_W   = clog2(BAR_H);

  localparam logic [HC_W-1:0]  H_LAST     = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0]  V_LAST     = VC_W'(V_TOTAL - 1);
  localparam logic [HC_W-1:0]  H_ACT_LAST = HC_W'(H_ACTIVE - 1);
  localparam logic [VC_W-1:0]  V_ACT_LAST = VC_W'(V_ACTIVE - 1);
  localparam logic [VC_W-1:0]  V_ACT      = VC_W'(V_ACTIVE);
  localparam logic [BPX_W-1:0] BAR_W_LAST = BPX_W'(BAR_W - 1);
  localparam logic [BPY_W-1:0] BAR_H_LAST = BPY_W'(BAR_H - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BARS - 1);

  logic [HC_W-1:0] w_h_cnt;
  logic [VC_W-1:0] w_v_cnt;
  logic            w_pix_ce;
  logic            w_hs_act;
  logic            w_vs_act;
  logic            w_de;

  vga_timing_core #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_enable (i_enable),
    .o_h_cnt  (w_h_cnt),
    .o_v_cnt  (w_v_cnt),
    .o_pix_ce (w_pix_ce),
    .o_hs_act (w_hs_act),
    .o_vs_act (w_vs_act),
    .o_de     (w_de)
  );

  mode_e                     r_mode;
  logic [NUM_BARS*PIX_W-1:0] r_bar_colors;
  logic [PIX_W-1:0]          r_solid;
  mode_e                     w_mode;
  logic [NUM_BARS*PIX_W-1:0] w_bar_colors;
  logic [PIX_W-1:0]          w_solid;
  logic                      w_at_origin;

  logic [BPX_W-1:0] r_bar_px_x;
  logic [IDX_W-1:0] r_bar_idx_x;
  logic [BPY_W-1:0] r_bar_px_y;
  logic [IDX_W-1:0] r_bar_idx_y;

  logic [PIX_W-1:0] w_pix;
  logic [PIX_W-1:0] r_rgb;
  logic             r_hs;
  logic             r_vs;
  logic             r_de;
  logic             r_frame_start;
  logic             r_line_start;

  assign w_at_origin = (w_h_cnt == '0) && (w_v_cnt == '0);

  // At the origin the latch captures the live inputs. The mux also uses
  // the live inputs at that pixel, so a new frame's settings take effect
  // from pixel (0,0) and not one pixel later.
  assign w_mode       = w_at_origin ? mode_e'(i_mode) : r_mode;
  assign w_bar_colors = w_at_origin ? i_bar_colors    : r_bar_colors;
  assign w_solid      = w_at_origin ? i_solid_color   : r_solid;

  // The frame latch keeps the colours and mode fixed for the whole frame.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_mode       <= MODE_VBARS;
      r_bar_colors <= '0;
      r_solid      <= '0;
    end else if (w_pix_ce && w_at_origin) begin
      r_mode       <= mode_e'(i_mode);
      r_bar_colors <= i_bar_colors;
      r_solid      <= i_solid_color;
    end
  end

  // Bar and band indices are found without a divider. A pixel counter
  // rolls over every BAR_W pixels (BAR_H lines) and steps the index. The
  // index saturates, so the leftover pixels take the last bar's colour.
  // The registers always describe the position the counters hold now.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_bar_px_x  <= '0;
      r_bar_idx_x <= '0;
      r_bar_px_y  <= '0;
      r_bar_idx_y <= '0;
    end else if (w_pix_ce) begin
      if (w_h_cnt == H_LAST) begin
        r_bar_px_x  <= '0;
        r_bar_idx_x <= '0;
        if (w_v_cnt == V_LAST) begin
          r_bar_px_y  <= '0;
          r_bar_idx_y <= '0;
        end else if (r_bar_px_y == BAR_H_LAST) begin
          r_bar_px_y <= '0;
          if (r_bar_idx_y != IDX_LAST) r_bar_idx_y <= r_bar_idx_y + 1'b1;
        end else begin
          r_bar_px_y <= r_bar_px_y + 1'b1;
        end
      end else if (r_bar_px_x == BAR_W_LAST) begin
        r_bar_px_x <= '0;
        if (r_bar_idx_x != IDX_LAST) r_bar_idx_x <= r_bar_idx_x + 1'b1;
      end else begin
        r_bar_px_x <= r_bar_px_x + 1'b1;
      end
    end
  end

  // The colour mux picks a colour for the pixel the counters point at.
  // Anything outside the active picture is forced to black.
  always_comb begin
    w_pix = '0;
    case (w_mode)
      MODE_VBARS:  w_pix = w_bar_colors[int'(r_bar_idx_x)*PIX_W +: PIX_W];
      MODE_SOLID:  w_pix = w_solid;
      MODE_BORDER: begin
        if ((w_h_cnt == '0) || (w_h_cnt == H_ACT_LAST) ||
            (w_v_cnt == '0) || (w_v_cnt == V_ACT_LAST))
          w_pix = w_solid;
      end
      MODE_HBANDS: w_pix = w_bar_colors[int'(r_bar_idx_y)*PIX_W +: PIX_W];
    endcase
    if (!w_de) w_pix = '0;
  end

  // The output stage registers everything together on the pixel enable,
  // which keeps sync, DE, colour and the strobes aligned. Each strobe is
  // cleared on the next CLK, so it lasts exactly one CLK.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
      if (w_pix_ce) begin
        r_hs          <= w_hs_act ? HS_POL : ~HS_POL;
        r_vs          <= w_vs_act ? VS_POL : ~VS_POL;
        r_de          <= w_de;
        r_rgb         <= w_pix;
        r_frame_start <= w_at_origin;
        r_line_start  <= (w_h_cnt == '0) && (w_v_cnt < V_ACT);
      end
    end
  end

  assign o_vga_hs      = r_hs;
  assign o_vga_vs      = r_vs;
  assign o_vga_de      = r_de;
  assign o_vga_r       = r_rgb[PIX_W-1 -: R_W];
  assign o_vga_g       = r_rgb[B_W +: G_W];
  assign o_vga_b       = r_rgb[B_W-1:0];
  assign o_frame_start = r_frame_start;
  assign o_line_start  = r_line_start;

endmodule

// File: tb/tb_vga_bar_gen.sv
// tb_vga_bar_gen
//   Directed bench for vga_bar_gen. It uses a shrunken raster of 24 pixels
//   by 12 lines, with a 16x8 active area and 576 CLK per frame for dut A.
//   Dut A has CLK_DIV=2, four bars and active-low syncs. Dut B has
//   CLK_DIV=1, three bars that leave a remainder, and active-high syncs.
module tb_vga_bar_gen;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable;
  logic [1:0]  mode;
  logic [15:0] solid;
  logic [63:0] barsA;
  logic [47:0] barsB;

  logic       hsA, vsA, deA, fsA, lsA;
  logic [4:0] rA, bA;
  logic [5:0] gA;
  logic       hsB, vsB, deB, fsB, lsB;
  logic [4:0] rB, bB;
  logic [5:0] gB;

  int testsRun = 0;
  int testsFailed = 0;
  int curPix = 0;

  vga_bar_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .NUM_BARS(4),
    .R_W(5), .G_W(6), .B_W(5)
  ) dutA (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_mode(mode),
    .i_bar_colors(barsA), .i_solid_color(solid),
    .o_vga_hs(hsA), .o_vga_vs(vsA), .o_vga_de(deA),
    .o_vga_r(rA), .o_vga_g(gA), .o_vga_b(bA),
    .o_frame_start(fsA), .o_line_start(lsA)
  );

  vga_bar_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .NUM_BARS(3),
    .R_W(5), .G_W(6), .B_W(5)
  ) dutB (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_mode(mode),
    .i_bar_colors(barsB), .i_solid_color(solid),
    .o_vga_hs(hsB), .o_vga_vs(vsB), .o_vga_de(deB),
    .o_vga_r(rB), .o_vga_g(gB), .o_vga_b(bB),
    .o_frame_start(fsB), .o_line_start(lsB)
  );

  // These helpers read the packed {R,G,B} colour and the frame strobe of the selected dut.
  function automatic logic [15:0] rgbOf(input int sel);
    return (sel == 1) ? {rB, gB, bB} : {rA, gA, bA};
  endfunction

  function automatic logic fsOf(input int sel);
    return (sel == 1) ? fsB : fsA;
  endfunction

  // This drives the shared control inputs. Bar colours are written directly.
  task automatic applyStimulus(input logic rstV, input logic enV,
                               input logic [1:0] modeV, input logic [15:0] solidV);
    rst    = rstV;
    enable = enV;
    mode   = modeV;
    solid  = solidV;
  endtask

  // This makes one comparison, counts it, and reports it if it fails.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // This waits, with a cycle budget, for the next frame_start of a dut. It
  // leaves the bench at the negedge where pixel (0,0) is on the outputs.
  task automatic syncFrame(input int sel);
    int waited;
    logic found;
    waited = 0;
    found  = 1'b0;
    while (waited < 1200 && !found) begin
      @(negedge clk);
      waited++;
      if (fsOf(sel)) found = 1'b1;
    end
    checkOutput("frame_start_seen", {31'd0, found}, 32'd1);
    curPix = 0;
  endtask

  // This moves forward to the negedge where pixel (x,y) of the current frame is on the outputs.
  task automatic gotoPixel(input int sel, input int x, input int y);
    int n;
    int div;
    div = (sel == 1) ? 1 : 2;
    n = y * HT + x - curPix;
    if (n > 0) begin
      repeat (n * div) @(posedge clk);
      @(negedge clk);
    end
    curPix = y * HT + x;
  endtask

  task automatic checkRgb(input int sel, input int x, input int y,
                          input string tag, input logic [15:0] expected);
    gotoPixel(sel, x, y);
    checkOutput(tag, {16'd0, rgbOf(sel)}, {16'd0, expected});
  endtask

  initial begin
    int hsLow, vsLow, deHigh, lsCount, fsCount;

    barsA = {16'hFFFF, 16'h001F, 16'h07E0, 16'hF800};
    barsB = {16'h001F, 16'h07E0, 16'hF800};
    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000);
    repeat (3) @(negedge clk);

    // The reset state is idle syncs, no DE, black, and no strobes.
    checkOutput("rst_hsA", {31'd0, hsA}, 32'd1);
    checkOutput("rst_vsA", {31'd0, vsA}, 32'd1);
    checkOutput("rst_deA", {31'd0, deA}, 32'd0);
    checkOutput("rst_rgbA", {16'd0, rgbOf(0)}, 32'd0);
    checkOutput("rst_fsA", {31'd0, fsA}, 32'd0);
    checkOutput("rst_lsA", {31'd0, lsA}, 32'd0);
    checkOutput("rst_hsB_pol1", {31'd0, hsB}, 32'd0);
    checkOutput("rst_vsB_pol1", {31'd0, vsB}, 32'd0);

    // Releasing reset sends frame_start out one pixel period later.
    applyStimulus(1'b0, 1'b1, 2'd0, 16'h0000);
    @(negedge clk);
    checkOutput("start_fsA_early", {31'd0, fsA}, 32'd0);
    checkOutput("start_fsB_div1", {31'd0, fsB}, 32'd1);
    @(negedge clk);
    checkOutput("start_fsA", {31'd0, fsA}, 32'd1);
    checkOutput("start_lsA", {31'd0, lsA}, 32'd1);
    checkOutput("start_deA", {31'd0, deA}, 32'd1);
    checkOutput("start_rgbA", {16'd0, rgbOf(0)}, 32'h0000F800);

    // One full frame of dut A is counted CLK by CLK.
    hsLow = 0; vsLow = 0; deHigh = 0; lsCount = 0; fsCount = 0;
    for (int i = 0; i < 576; i++) begin
      if (!hsA) hsLow++;
      if (!vsA) vsLow++;
      if (deA)  deHigh++;
      if (lsA)  lsCount++;
      if (fsA)  fsCount++;
      @(negedge clk);
    end
    checkOutput("frame_hs_low_clk", hsLow, 72);
    checkOutput("frame_vs_low_clk", vsLow, 96);
    checkOutput("frame_de_high_clk", deHigh, 256);
    checkOutput("frame_line_starts", lsCount, 8);
    checkOutput("frame_fs_count", fsCount, 1);
    checkOutput("frame_fs_period", {31'd0, fsA}, 32'd1);
    curPix = 0;

    // In mode 0, the bars are four pixels wide and blanking is black.
    checkRgb(0, 3, 0, "m0_bar0_x3", 16'hF800);
    checkRgb(0, 4, 0, "m0_bar1_x4", 16'h07E0);
    checkRgb(0, 16, 0, "m0_blank_rgb", 16'h0000);
    checkOutput("m0_blank_de", {31'd0, deA}, 32'd0);
    gotoPixel(0, 17, 0);
    checkOutput("hs_before_sync", {31'd0, hsA}, 32'd1);
    gotoPixel(0, 18, 0);
    checkOutput("hs_sync_first", {31'd0, hsA}, 32'd0);
    gotoPixel(0, 20, 0);
    checkOutput("hs_sync_last", {31'd0, hsA}, 32'd0);
    gotoPixel(0, 21, 0);
    checkOutput("hs_after_sync", {31'd0, hsA}, 32'd1);
    checkRgb(0, 8, 2, "m0_bar2_x8", 16'h001F);
    checkRgb(0, 15, 7, "m0_bar3_x15", 16'hFFFF);
    gotoPixel(0, 0, 8);
    checkOutput("vs_line8_idle", {31'd0, vsA}, 32'd1);
    gotoPixel(0, 0, 9);
    checkOutput("vs_line9_sync", {31'd0, vsA}, 32'd0);
    gotoPixel(0, 0, 11);
    checkOutput("vs_line11_idle", {31'd0, vsA}, 32'd1);

    // A mid-frame change does not show until the next frame starts.
    syncFrame(0);
    gotoPixel(0, 0, 3);
    applyStimulus(1'b0, 1'b1, 2'd1, 16'hABCD);
    barsA = 64'd0;
    checkRgb(0, 4, 5, "latch_hold_bar1", 16'h07E0);
    checkRgb(0, 15, 6, "latch_hold_bar3", 16'hFFFF);
    syncFrame(0);
    checkOutput("latch_new_origin", {16'd0, rgbOf(0)}, 32'h0000ABCD);
    checkRgb(0, 7, 4, "m1_solid", 16'hABCD);

    // In mode 2, only the outer rows and columns are white.
    applyStimulus(1'b0, 1'b1, 2'd2, 16'hFFFF);
    syncFrame(0);
    checkOutput("m2_corner", {16'd0, rgbOf(0)}, 32'h0000FFFF);
    checkRgb(0, 5, 0, "m2_top_row", 16'hFFFF);
    checkRgb(0, 0, 3, "m2_left_col", 16'hFFFF);
    checkRgb(0, 1, 3, "m2_interior", 16'h0000);
    checkRgb(0, 15, 3, "m2_right_col", 16'hFFFF);
    checkRgb(0, 5, 7, "m2_bottom_row", 16'hFFFF);
    checkRgb(0, 16, 7, "m2_blank", 16'h0000);

    // In mode 3, the bands are two lines tall.
    barsA = {16'hFFFF, 16'h001F, 16'h07E0, 16'hF800};
    applyStimulus(1'b0, 1'b1, 2'd3, 16'hFFFF);
    syncFrame(0);
    checkRgb(0, 5, 1, "m3_band0_y1", 16'hF800);
    checkRgb(0, 5, 2, "m3_band1_y2", 16'h07E0);
    checkRgb(0, 5, 4, "m3_band2_y4", 16'h001F);
    checkRgb(0, 10, 5, "m3_band2_y5", 16'h001F);

    // A reset mid-frame aborts at once. Enable low then holds the idle state.
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_hsA", {31'd0, hsA}, 32'd1);
    checkOutput("abort_vsA", {31'd0, vsA}, 32'd1);
    checkOutput("abort_deA", {31'd0, deA}, 32'd0);
    checkOutput("abort_rgbA", {16'd0, rgbOf(0)}, 32'd0);
    applyStimulus(1'b0, 1'b0, 2'd3, 16'hFFFF);
    repeat (10) @(negedge clk);
    checkOutput("disabled_deA", {31'd0, deA}, 32'd0);
    checkOutput("disabled_hsA", {31'd0, hsA}, 32'd1);
    checkOutput("disabled_fsA", {31'd0, fsA}, 32'd0);
    enable = 1'b1;
    @(negedge clk);
    checkOutput("resume_fsA_early", {31'd0, fsA}, 32'd0);
    @(negedge clk);
    checkOutput("resume_fsA", {31'd0, fsA}, 32'd1);
    checkOutput("resume_rgbA", {16'd0, rgbOf(0)}, 32'h0000F800);

    // Dut B has three bars five pixels wide. The last bar takes x=10..15, and the syncs are active-high.
    mode = 2'd0;
    syncFrame(1);
    checkOutput("b_origin_rgb", {16'd0, rgbOf(1)}, 32'h0000F800);
    checkOutput("b_origin_ls", {31'd0, lsB}, 32'd1);
    checkOutput("b_origin_de", {31'd0, deB}, 32'd1);
    checkOutput("b_origin_hs_idle", {31'd0, hsB}, 32'd0);
    checkRgb(1, 4, 0, "b_bar0_x4", 16'hF800);
    checkRgb(1, 5, 0, "b_bar1_x5", 16'h07E0);
    checkRgb(1, 9, 0, "b_bar1_x9", 16'h07E0);
    checkRgb(1, 10, 0, "b_bar2_x10", 16'h001F);
    checkRgb(1, 15, 0, "b_bar2_x15", 16'h001F);
    gotoPixel(1, 18, 0);
    checkOutput("b_hs_active_high", {31'd0, hsB}, 32'd1);
    gotoPixel(1, 0, 9);
    checkOutput("b_vs_active_high", {31'd0, vsB}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vga_bar_gen.md
Name: vga_bar_gen

Overview:
Parametrised VGA timing generator with a built-in test-pattern engine. It is the next generation of the fixed 640x480 colour-bar driver.
- Timing, pixel-clock ratio, bar count and colour widths are all parameters.
- The pixel rate comes from a clock-enable on CLK rather than a derived clock.
- Adds DE, selectable sync polarity, frame-synchronous colour/mode update, four pattern modes and frame/line strobes.
- Sits between the bus register block (colour/mode registers) and the board VGA DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level
CLK_DIV, 4, CLK cycles per pixel (>=1)
NUM_BARS, 8, bar count (1..H_ACTIVE)
R_W, 5, red width
G_W, 6, green width
B_W, 5, blue width (PIX_W = R_W+G_W+B_W)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
enable  in  1  run when 1; when 0, timing is held in reset state
mode  in  2  0 vertical bars, 1 solid, 2 border, 3 horizontal bands
bar_colors  in  NUM_BARS*PIX_W  bar k = bar_colors[k*PIX_W +: PIX_W], packed {R,G,B} MSB-first
solid_color  in  PIX_W  colour for mode 1 and the mode-2 border
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_de  out  1  active-video flag
vga_r  out  R_W  red
vga_g  out  G_W  green
vga_b  out  B_W  blue
frame_start  out  1  one-CLK pulse, asserted when pixel (0,0) appears on the outputs
line_start  out  1  one-CLK pulse, asserted when pixel x=0 of any active line appears

Behaviour:
- Clocking and reset:
  - Single clock CLK; all state is updated on its rising edge.
  - RST (synchronous, active-high) or enable=0 forces, on the next edge:
    - div_cnt=0, h_cnt=0, v_cnt=0
    - vga_hs=~HS_POL, vga_vs=~VS_POL
    - vga_de=0, rgb=0, strobes=0
    - latched colours/mode=0
  - RST has priority over enable.
  - Asserting RST mid-frame aborts immediately; there is no completion of the line.
- Pixel enable:
  - div_cnt counts 0..CLK_DIV-1.
  - pix_ce=1 when div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, pix_ce is constantly 1.
- Counters (advance only on pix_ce):
  - h_cnt runs 0..H_TOTAL-1 and wraps.
  - v_cnt increments when h_cnt wraps, and wraps at V_TOTAL-1.
  - Line ordering: active, FP, sync, BP; active starts at 0.
- Sync and DE generation:
  - hs_act = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vs_act is the same form on v_cnt.
  - de = h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- Latency:
  - All outputs are registered and updated on pix_ce.
  - Outputs lag the counters by exactly one pixel period; sync, DE and colour are mutually aligned.
- Frame latch:
  - bar_colors, solid_color and mode are captured on the pix_ce where h_cnt==0 and v_cnt==0 (pre-output).
  - Changes at any other time have no visible effect until the next frame.
- Bar index:
  - Uses no divider. A bar pixel counter and bar_idx both clear at h_cnt==0.
  - At each pixel, bar_px increments; when it reaches BAR_W=H_ACTIVE/NUM_BARS, bar_idx increments, saturating at NUM_BARS-1.
  - The remainder pixels therefore take the last bar's colour.
  - Mode 3 uses the same scheme on v_cnt, with BAR_H=V_ACTIVE/NUM_BARS and clearing at v_cnt==0.
- Colour selection:
  - Mode 0: bar[bar_idx_x].
  - Mode 1: solid_color.
  - Mode 2: solid_color where x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1; 0 elsewhere.
  - Mode 3: bar[bar_idx_y].
  - When de=0, rgb is forced to 0.
- Strobes:
  - Asserted for the single CLK cycle in which the corresponding registered output first becomes valid.
  - They never overlap with reset.

Decomposition:
- Package vga_bar_pkg holds:
  - mode encodings MODE_VBARS/MODE_SOLID/MODE_BORDER/MODE_HBANDS
  - function clog2
  - H_TOTAL/V_TOTAL derivation helpers
- Sub-module vga_timing_core holds div_cnt, h/v counters, hs/vs/de generation and pix_ce.
  - It exposes h_cnt, v_cnt, pix_ce, hs_act, vs_act and de.
- The top level holds the frame latch, bar indexing, colour mux and output registers.

Test Plan:
1. Defaults, enable=1 after RST → per line: vga_hs low 384 CLK in a 3200-CLK period and vga_de high 2560 CLK. vga_vs low 6400 CLK per 1,680,000-CLK frame. 480 DE lines per frame; frame_start period 1,680,000 CLK.
2. Mode 0, bar0=16'hF800, bar7=16'h001F → x=0..79 gives r=31,g=0,b=0; x=560..639 gives r=0,g=0,b=31; blanking gives rgb=0.
3. NUM_BARS=7 → BAR_W=91; bars 0..5 each 91 pixels; bar 6 covers x=546..639 (94 pixels).
4. Change bar_colors and mode at line 100 → outputs unchanged until the next frame_start; new values appear from pixel (0,0) onward.
5. Mode 2, solid=16'hFFFF → white only on row 0, row 479, column 0 and column 639; interior 0. Mode 3 → y=0..59 shows bar0, y=420..479 shows bar7.
6. RST pulsed 1 CLK at h=300, v=200 (also enable=0 for 10 CLK) → next edge: hs=vs=1, de=0, rgb=0. After release, the first frame_start occurs exactly one pixel period after counting resumes from (0,0). HS_POL=1 run shows inverted sync.
